// File: rtl/smi_mem_lib_burst_responder64_if.sv
// SMI request/response channel bundle between a burst initiator (master) and the memory responder (slave).
interface smi_mem_lib_burst_responder64_if;
    logic        smiReqValid;
    logic [7:0]  smiReqEofc;
    logic [63:0] smiReqData;
    logic        smiReqStop;
    logic        smiRespValid;
    logic [7:0]  smiRespEofc;
    logic [63:0] smiRespData;
    logic        smiRespStop;

    modport master (
        output smiReqValid, smiReqEofc, smiReqData, smiRespStop,
        input  smiReqStop, smiRespValid, smiRespEofc, smiRespData
    );
    modport slave (
        input  smiReqValid, smiReqEofc, smiReqData, smiRespStop,
        output smiReqStop, smiRespValid, smiRespEofc, smiRespData
    );
endinterface

// File: rtl/smi_mem_lib_burst_responder64.sv
// SMI burst memory responder: accepts 64-bit write/read burst frames, backs them with a
// synchronous RAM window and returns status or read-data response frames.
module smi_mem_lib_burst_responder64 #(
    parameter int          AddrWidth      = 10,
    parameter logic [63:0] BaseAddr       = 64'h0000000000000000,
    parameter int          MaxBurstLength = 8192
) (
    input  logic                           clk,
    input  logic                           arst_n,
    smi_mem_lib_burst_responder64_if.slave smi
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WRDATA = 3'd2,
        DRAIN  = 3'd3,
        RESP   = 3'd4,
        RDHDR  = 3'd5,
        RDDATA = 3'd6
    } state_t;

    localparam logic [7:0]           OpWrite  = 8'h01;
    localparam logic [7:0]           OpRead   = 8'h02;
    localparam logic [7:0]           EofcFull = 8'd8;
    localparam logic [16:0]          MaxLen   = 17'(MaxBurstLength);
    localparam logic [64:0]          WinEnd   = {1'b0, BaseAddr} + (65'd8 << AddrWidth);
    localparam logic [AddrWidth-1:0] IdxOne   = AddrWidth'(1);

    // Response header: reply opcode has bit 7 set, status sits in [23:16].
    function automatic logic [63:0] mkHdr(input logic [7:0] op, input logic [7:0] tag, input logic err);
        return {40'd0, 7'd0, err, tag, op | 8'h80};
    endfunction

    state_t               state_r;
    logic [7:0]           opcode_r;
    logic [7:0]           tag_r;
    logic [15:0]          len_r;
    logic [12:0]          wordCnt_r;
    logic [AddrWidth-1:0] wrIdx_r;
    logic [AddrWidth-1:0] rdIdx_r;
    logic [12:0]          rdRemain_r;
    logic                 rdPending_r;
    logic                 rdLastPend_r;
    logic                 reqStop_r;
    logic                 outValid_r;
    logic [7:0]           outEofc_r;
    logic [63:0]          outData_r;
    logic                 skidValid_r;
    logic [7:0]           skidEofc_r;
    logic [63:0]          skidData_r;
    logic [63:0]          ramQ_r;
    logic [63:0]          ram_r [0:(2**AddrWidth)-1];

    logic                 reqFire_s;
    logic                 respFire_s;
    logic                 reqLast_s;
    logic [64:0]          wordOff65_s;
    logic [63:0]          wordOff_s;
    logic [AddrWidth-1:0] reqIdx_s;
    logic [64:0]          endAddr_s;
    logic                 frameErr_s;
    logic                 writeGo_s;
    logic                 readGo_s;
    logic                 wrOk_s;
    logic                 ramWe_s;
    logic                 ramRe_s;
    logic [AddrWidth-1:0] ramRaddr_s;
    logic [1:0]           occ_s;
    logic [7:0]           pendEofc_s;
    logic                 unusedBits_s;

    // Handshakes, address-flit checks, data-flit checks and RAM port control.
    always_comb begin
        reqFire_s    = smi.smiReqValid && !reqStop_r;
        respFire_s   = outValid_r && !smi.smiRespStop;
        reqLast_s    = (smi.smiReqEofc != 8'd0);
        // Borrow out of the 65-bit subtraction flags an address below the window.
        wordOff65_s  = {1'b0, smi.smiReqData} - {1'b0, BaseAddr};
        wordOff_s    = wordOff65_s[63:0];
        reqIdx_s     = wordOff_s[AddrWidth+2:3];
        endAddr_s    = {1'b0, smi.smiReqData} + {49'd0, len_r};
        frameErr_s   = ((opcode_r != OpWrite) && (opcode_r != OpRead))
                    || (len_r == 16'd0) || (len_r[2:0] != 3'd0) || ({1'b0, len_r} > MaxLen)
                    || (smi.smiReqData[2:0] != 3'd0) || wordOff65_s[64] || (endAddr_s > WinEnd);
        writeGo_s    = !frameErr_s && (opcode_r == OpWrite) && !reqLast_s;
        readGo_s     = (state_r == ADDR) && reqFire_s && !frameErr_s
                    && (opcode_r == OpRead) && (smi.smiReqEofc == EofcFull);
        if (wordCnt_r == 13'd1) begin
            wrOk_s = (smi.smiReqEofc == EofcFull);
        end else begin
            wrOk_s = !reqLast_s;
        end
        ramWe_s      = (state_r == WRDATA) && reqFire_s && wrOk_s;
        occ_s        = {1'b0, outValid_r} + {1'b0, skidValid_r} + {1'b0, rdPending_r} - {1'b0, respFire_s};
        pendEofc_s   = rdLastPend_r ? EofcFull : 8'd0;
        ramRe_s      = 1'b0;
        ramRaddr_s   = rdIdx_r;
        if (readGo_s) begin
            ramRe_s    = 1'b1;
            ramRaddr_s = reqIdx_s;
        end else if (((state_r == RDHDR) || (state_r == RDDATA)) && (rdRemain_r != 13'd0) && (occ_s < 2'd2)) begin
            ramRe_s    = 1'b1;
        end else begin
            ramRe_s    = 1'b0;
        end
        unusedBits_s = ^{wordOff_s[63:AddrWidth+3], wordOff_s[2:0]};
    end

    // Frame sequencing, request backpressure and the registered response buffer.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r      <= IDLE;
            opcode_r     <= 8'd0;
            tag_r        <= 8'd0;
            len_r        <= 16'd0;
            wordCnt_r    <= 13'd0;
            wrIdx_r      <= '0;
            rdIdx_r      <= '0;
            rdRemain_r   <= 13'd0;
            rdPending_r  <= 1'b0;
            rdLastPend_r <= 1'b0;
            reqStop_r    <= 1'b1;
            outValid_r   <= 1'b0;
            outEofc_r    <= 8'd0;
            outData_r    <= 64'd0;
            skidValid_r  <= 1'b0;
            skidEofc_r   <= 8'd0;
            skidData_r   <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    reqStop_r <= 1'b0;
                    if (reqFire_s) begin
                        opcode_r <= smi.smiReqData[7:0];
                        tag_r    <= smi.smiReqData[15:8];
                        len_r    <= smi.smiReqData[31:16];
                        if (reqLast_s) begin
                            state_r    <= RESP;
                            reqStop_r  <= 1'b1;
                            outValid_r <= 1'b1;
                            outEofc_r  <= EofcFull;
                            outData_r  <= mkHdr(smi.smiReqData[7:0], smi.smiReqData[15:8], 1'b1);
                        end else begin
                            state_r <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (reqFire_s) begin
                        wrIdx_r   <= reqIdx_s;
                        wordCnt_r <= len_r[15:3];
                        if (writeGo_s) begin
                            state_r <= WRDATA;
                        end else if (readGo_s) begin
                            state_r      <= RDHDR;
                            reqStop_r    <= 1'b1;
                            outValid_r   <= 1'b1;
                            outEofc_r    <= 8'd0;
                            outData_r    <= mkHdr(opcode_r, tag_r, 1'b0);
                            skidValid_r  <= 1'b0;
                            rdIdx_r      <= reqIdx_s + IdxOne;
                            rdRemain_r   <= len_r[15:3] - 13'd1;
                            rdPending_r  <= 1'b1;
                            rdLastPend_r <= (len_r[15:3] == 13'd1);
                        end else if (!reqLast_s) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r    <= RESP;
                            reqStop_r  <= 1'b1;
                            outValid_r <= 1'b1;
                            outEofc_r  <= EofcFull;
                            outData_r  <= mkHdr(opcode_r, tag_r, 1'b1);
                        end
                    end
                end
                WRDATA: begin
                    if (reqFire_s) begin
                        wrIdx_r   <= wrIdx_r + IdxOne;
                        wordCnt_r <= wordCnt_r - 13'd1;
                        if (wrOk_s && (wordCnt_r == 13'd1)) begin
                            state_r    <= RESP;
                            reqStop_r  <= 1'b1;
                            outValid_r <= 1'b1;
                            outEofc_r  <= EofcFull;
                            outData_r  <= mkHdr(opcode_r, tag_r, 1'b0);
                        end else if (!wrOk_s && !reqLast_s) begin
                            state_r <= DRAIN;
                        end else if (!wrOk_s) begin
                            state_r    <= RESP;
                            reqStop_r  <= 1'b1;
                            outValid_r <= 1'b1;
                            outEofc_r  <= EofcFull;
                            outData_r  <= mkHdr(opcode_r, tag_r, 1'b1);
                        end
                    end
                end
                DRAIN: begin
                    if (reqFire_s && reqLast_s) begin
                        state_r    <= RESP;
                        reqStop_r  <= 1'b1;
                        outValid_r <= 1'b1;
                        outEofc_r  <= EofcFull;
                        outData_r  <= mkHdr(opcode_r, tag_r, 1'b1);
                    end
                end
                RESP: begin
                    if (respFire_s) begin
                        state_r    <= IDLE;
                        reqStop_r  <= 1'b0;
                        outValid_r <= 1'b0;
                    end
                end
                RDHDR, RDDATA: begin
                    // Two-entry queue (out, skid); a RAM word lands the cycle after its read.
                    if (respFire_s) begin
                        if (skidValid_r) begin
                            outData_r  <= skidData_r;
                            outEofc_r  <= skidEofc_r;
                            outValid_r <= 1'b1;
                            skidValid_r <= rdPending_r;
                            skidData_r  <= ramQ_r;
                            skidEofc_r  <= pendEofc_s;
                        end else if (rdPending_r) begin
                            outData_r  <= ramQ_r;
                            outEofc_r  <= pendEofc_s;
                            outValid_r <= 1'b1;
                        end else begin
                            outValid_r <= 1'b0;
                        end
                    end else if (rdPending_r) begin
                        if (outValid_r) begin
                            skidData_r  <= ramQ_r;
                            skidEofc_r  <= pendEofc_s;
                            skidValid_r <= 1'b1;
                        end else begin
                            outData_r  <= ramQ_r;
                            outEofc_r  <= pendEofc_s;
                            outValid_r <= 1'b1;
                        end
                    end
                    if (ramRe_s) begin
                        rdIdx_r      <= rdIdx_r + IdxOne;
                        rdRemain_r   <= rdRemain_r - 13'd1;
                        rdPending_r  <= 1'b1;
                        rdLastPend_r <= (rdRemain_r == 13'd1);
                    end else begin
                        rdPending_r <= 1'b0;
                    end
                    if (respFire_s && (state_r == RDHDR)) begin
                        state_r <= RDDATA;
                    end else if (respFire_s && (outEofc_r == EofcFull)) begin
                        state_r   <= IDLE;
                        reqStop_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    reqStop_r   <= 1'b1;
                    outValid_r  <= 1'b0;
                    skidValid_r <= 1'b0;
                    rdPending_r <= 1'b0;
                end
            endcase
        end
    end

    // RAM window: write on accepted data flits, registered read port.
    always_ff @(posedge clk) begin
        if (ramWe_s) begin
            ram_r[wrIdx_r] <= smi.smiReqData;
        end
        if (ramRe_s) begin
            ramQ_r <= ram_r[ramRaddr_s];
        end
    end

    assign smi.smiReqStop   = reqStop_r;
    assign smi.smiRespValid = outValid_r;
    assign smi.smiRespEofc  = outEofc_r;
    assign smi.smiRespData  = outData_r;

endmodule

// File: tb/tb_smi_mem_lib_burst_responder64.sv
// Directed self-checking bench for the SMI burst memory responder.
module tb_smi_mem_lib_burst_responder64;

    logic clk = 1'b0;
    logic arst_n;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] txData [0:1100];
    logic [7:0]  txEofc [0:1100];
    int          txN;
    logic [63:0] rxData [0:1100];
    logic [7:0]  rxEofc [0:1100];
    int          rxCyc  [0:1100];

    smi_mem_lib_burst_responder64_if bus();

    smi_mem_lib_burst_responder64 #(
        .AddrWidth(10), .BaseAddr(64'h0), .MaxBurstLength(8192)
    ) dut (
        .clk(clk), .arst_n(arst_n), .smi(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int k);
        return 64'hC0DE_0000_0000_0000 | 64'(k);
    endfunction

    task automatic frame_start(input logic [7:0] op, input logic [7:0] tag, input logic [15:0] len,
                               input logic [63:0] addr, input logic [7:0] eofc1);
        txData[0] = {32'd0, len, tag, op}; txEofc[0] = 8'd0;
        txData[1] = addr;                  txEofc[1] = eofc1;
        txN = 2;
    endtask

    task automatic send_flit(input logic [7:0] e, input logic [63:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.smiReqValid = 1'b1; bus.smiReqEofc = e; bus.smiReqData = d;
        while (bus.smiReqStop && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            $display("FAIL req_stop_timeout: smiReqStop stayed 1, required 0 within 300 cycles");
            $fatal(1, "request channel stalled");
        end
        @(posedge clk);
    endtask

    task automatic send_frame();
        for (int i = 0; i < txN; i++) send_flit(txEofc[i], txData[i]);
        #1 bus.smiReqValid = 1'b0;
    endtask

    task automatic collect(input int stopPct, output int n);
        int cyc;
        bit done;
        n = 0; cyc = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            bus.smiRespStop = ($urandom_range(99) < stopPct) ? 1'b1 : 1'b0;
            if (bus.smiRespValid && !bus.smiRespStop) begin
                rxData[n] = bus.smiRespData; rxEofc[n] = bus.smiRespEofc; rxCyc[n] = cyc;
                n++;
                if (bus.smiRespEofc != 8'd0 || n > 1100) done = 1'b1;
            end
            cyc++;
            if (!done && cyc > 20000) begin
                $display("FAIL resp_timeout: response frame incomplete after %0d cycles, %0d flits", cyc, n);
                $fatal(1, "response channel stalled");
            end
        end
        @(posedge clk);
        #1 bus.smiRespStop = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b1;
        #1 arst_n = 1'b0;
        #1;
        checks++; if (bus.smiReqStop !== 1'b1) begin errors++; $display("FAIL reset_req_stop: got %b expected 1", bus.smiReqStop); end
        checks++; if (bus.smiRespValid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.smiRespValid); end
        checks++; if (bus.smiRespEofc !== 8'd0) begin errors++; $display("FAIL reset_resp_eofc: got %h expected 00", bus.smiRespEofc); end
        checks++; if (bus.smiRespData !== 64'd0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", bus.smiRespData); end
        @(negedge clk); @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (bus.smiReqStop !== 1'b0) begin errors++; $display("FAIL idle_req_stop: got %b expected 0", bus.smiReqStop); end
    endtask

    task automatic test_write_read();
        int n;
        int bad;
        frame_start(8'h01, 8'h11, 16'd64, 64'h40, 8'd0);
        for (int k = 0; k < 8; k++) begin
            txData[2+k] = 64'(k); txEofc[2+k] = (k == 7) ? 8'd8 : 8'd0;
        end
        txN = 10;
        send_frame();
        collect(0, n);
        checks++; if (n !== 1 || rxData[0] !== 64'h0000_0000_0000_1181 || rxEofc[0] !== 8'd8) begin
            errors++; $display("FAIL wr_resp: got n=%0d %h eofc %0d expected n=1 0000000000001181 eofc 8", n, rxData[0], rxEofc[0]);
        end
        checks++; if (rxCyc[0] !== 0) begin errors++; $display("FAIL wr_resp_latency: got cycle %0d expected 0", rxCyc[0]); end
        frame_start(8'h02, 8'h12, 16'd64, 64'h40, 8'd8);
        send_frame();
        collect(0, n);
        checks++; if (n !== 9) begin errors++; $display("FAIL rd_count: got %0d expected 9", n); end
        checks++; if (rxData[0] !== 64'h0000_0000_0000_1282 || rxEofc[0] !== 8'd0) begin
            errors++; $display("FAIL rd_hdr: got %h eofc %0d expected 0000000000001282 eofc 0", rxData[0], rxEofc[0]);
        end
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (rxData[1+k] !== 64'(k) || rxEofc[1+k] !== ((k == 7) ? 8'd8 : 8'd0)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rd_data: got %0d bad flits expected 0", bad); end
        checks++; if (rxCyc[0] !== 0 || rxCyc[8] - rxCyc[0] !== 8) begin
            errors++; $display("FAIL rd_stream_rate: got first %0d span %0d expected first 0 span 8", rxCyc[0], rxCyc[8] - rxCyc[0]);
        end
    endtask

    task automatic test_bad_len_read();
        int n;
        frame_start(8'h02, 8'h22, 16'd12, 64'h0, 8'd8);
        send_frame();
        collect(0, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL badlen_count: got %0d expected 1", n); end
        checks++; if (rxData[0] !== 64'h0000_0000_0001_2282 || rxEofc[0] !== 8'd8) begin
            errors++; $display("FAIL badlen_hdr: got %h eofc %0d expected 0000000000012282 eofc 8", rxData[0], rxEofc[0]);
        end
    endtask

    task automatic test_window_overflow();
        int n;
        frame_start(8'h01, 8'h31, 16'd8, 64'h1FF8, 8'd0);
        txData[2] = 64'h1234_5678_9ABC_DEF0; txEofc[2] = 8'd8; txN = 3;
        send_frame();
        collect(0, n);
        checks++; if (n !== 1 || rxData[0] !== 64'h0000_0000_0000_3181) begin
            errors++; $display("FAIL top_write_ok: got n=%0d %h expected n=1 0000000000003181", n, rxData[0]);
        end
        frame_start(8'h01, 8'h32, 16'd16, 64'h1FF8, 8'd0);
        txData[2] = 64'hDEAD_BEEF_0000_0001; txEofc[2] = 8'd0;
        txData[3] = 64'hDEAD_BEEF_0000_0002; txEofc[3] = 8'd8; txN = 4;
        send_frame();
        collect(0, n);
        checks++; if (n !== 1 || rxData[0] !== 64'h0000_0000_0001_3281 || rxEofc[0] !== 8'd8) begin
            errors++; $display("FAIL overflow_resp: got n=%0d %h eofc %0d expected n=1 0000000000013281 eofc 8", n, rxData[0], rxEofc[0]);
        end
        frame_start(8'h02, 8'h33, 16'd8, 64'h1FF8, 8'd8);
        send_frame();
        collect(0, n);
        checks++; if (n !== 2 || rxData[1] !== 64'h1234_5678_9ABC_DEF0 || rxEofc[1] !== 8'd8) begin
            errors++; $display("FAIL overflow_ram: got n=%0d %h expected n=2 123456789abcdef0", n, rxData[1]);
        end
    endtask

    task automatic test_long_read();
        int n;
        int bad;
        frame_start(8'h01, 8'h43, 16'h2000, 64'h0, 8'd0);
        for (int k = 0; k < 1024; k++) begin
            txData[2+k] = pat(k); txEofc[2+k] = (k == 1023) ? 8'd8 : 8'd0;
        end
        txN = 1026;
        send_frame();
        collect(0, n);
        checks++; if (n !== 1 || rxData[0] !== 64'h0000_0000_0000_4381) begin
            errors++; $display("FAIL fill_resp: got n=%0d %h expected n=1 0000000000004381", n, rxData[0]);
        end
        frame_start(8'h02, 8'h44, 16'h2000, 64'h0, 8'd8);
        send_frame();
        collect(50, n);
        checks++; if (n !== 1025) begin errors++; $display("FAIL long_count: got %0d expected 1025", n); end
        checks++; if (rxData[0] !== 64'h0000_0000_0000_4482 || rxEofc[0] !== 8'd0) begin
            errors++; $display("FAIL long_hdr: got %h eofc %0d expected 0000000000004482 eofc 0", rxData[0], rxEofc[0]);
        end
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (rxData[1+k] !== pat(k) || rxEofc[1+k] !== ((k == 1023) ? 8'd8 : 8'd0)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL long_data: got %0d bad flits expected 0", bad); end
    endtask

    task automatic test_early_eof();
        int n;
        frame_start(8'h01, 8'h55, 16'd64, 64'h100, 8'd0);
        txData[2] = 64'hAAAA_0000_0000_0001; txEofc[2] = 8'd0;
        txData[3] = 64'hAAAA_0000_0000_0002; txEofc[3] = 8'd0;
        txData[4] = 64'hAAAA_0000_0000_0003; txEofc[4] = 8'd8; txN = 5;
        send_frame();
        collect(0, n);
        checks++; if (n !== 1 || rxData[0] !== 64'h0000_0000_0001_5581 || rxEofc[0] !== 8'd8) begin
            errors++; $display("FAIL early_eof_resp: got n=%0d %h eofc %0d expected n=1 0000000000015581 eofc 8", n, rxData[0], rxEofc[0]);
        end
        frame_start(8'h02, 8'h56, 16'd16, 64'h200, 8'd8);
        send_frame();
        collect(0, n);
        checks++; if (n !== 3 || rxData[0] !== 64'h0000_0000_0000_5682 || rxData[1] !== pat(64)
                      || rxData[2] !== pat(65) || rxEofc[2] !== 8'd8) begin
            errors++; $display("FAIL after_eof_read: got n=%0d %h %h %h expected n=3 0000000000005682 %h %h",
                               n, rxData[0], rxData[1], rxData[2], pat(64), pat(65));
        end
    endtask

    task automatic test_reset_mid_stream();
        int n;
        frame_start(8'h02, 8'h66, 16'd64, 64'h0, 8'd8);
        send_frame();
        repeat (3) @(negedge clk);
        checks++; if (bus.smiRespValid !== 1'b1 || bus.smiRespData !== pat(1)) begin
            errors++; $display("FAIL pre_reset_stream: got valid %b %h expected 1 %h", bus.smiRespValid, bus.smiRespData, pat(1));
        end
        arst_n = 1'b0;
        #1;
        checks++; if (bus.smiRespValid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", bus.smiRespValid); end
        checks++; if (bus.smiReqStop !== 1'b1) begin errors++; $display("FAIL midreset_stop: got %b expected 1", bus.smiReqStop); end
        @(negedge clk); @(negedge clk);
        arst_n = 1'b1;
        frame_start(8'h02, 8'h67, 16'd16, 64'h18, 8'd8);
        send_frame();
        collect(0, n);
        checks++; if (n !== 3 || rxData[0] !== 64'h0000_0000_0000_6782 || rxData[1] !== pat(3)
                      || rxData[2] !== pat(4) || rxEofc[2] !== 8'd8) begin
            errors++; $display("FAIL post_reset_read: got n=%0d %h %h %h expected n=3 0000000000006782 %h %h",
                               n, rxData[0], rxData[1], rxData[2], pat(3), pat(4));
        end
    endtask

    initial begin
        bus.smiReqValid = 1'b0;
        bus.smiReqEofc  = 8'd0;
        bus.smiReqData  = 64'd0;
        bus.smiRespStop = 1'b0;
        test_reset();
        test_write_read();
        test_bad_len_read();
        test_window_overflow();
        test_long_read();
        test_early_eof();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
